stall_ctrl: RTL and testbench

//  Hazard/stall controller for the 5-stage pipeline; drives the F_D stall and the D_E bubble.
//  - Compares D-stage source registers and Tuse against E/M destinations and Tnew.
//  - Tracks the multi-cycle mult/div unit with a busy countdown timer.
//  - Counts total stall cycles for performance reporting.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/md_busy_timer.sv | 54 +++++
 rtl/stall_ctrl.sv | 75 +++++++
 tb/tb_stall_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants and hazard helper for the pipeline stall logic.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam logic [1:0] TUSE_NONE    = 2'd3;
    localparam int         MULT_CYC_DEF = 5;
    localparam int         DIV_CYC_DEF  = 10;
    localparam int         MD_CNT_W     = $clog2(DIV_CYC_DEF + 1);

    // A source hazards against a stage when it names that stage's live
    // destination and is needed before the stage's result becomes ready.
    function automatic logic reg_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] a3,
        input logic [1:0] tnew
    );
        return (src != 5'd0) && (src == a3) &&
               (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/md_busy_timer.sv
`default_nettype none
// ============================================================================
// Module      : md_busy_timer
// Description : Busy countdown for the multi-cycle mult/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
module md_busy_timer
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int            CW          = $clog2(DIV_CYC + 1);
    localparam logic [CW-1:0] c_mult_load = CW'(MULT_CYC);
    localparam logic [CW-1:0] c_div_load  = CW'(DIV_CYC);
    localparam logic [CW-1:0] c_one       = CW'(1);

    logic [CW-1:0] r_md_cnt;
    logic          r_md_busy;

    // A start arriving while already busy falls through to the countdown
    // branch, so the running operation is never restarted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_md_cnt  <= '0;
            r_md_busy <= 1'b0;
        end else if (start && !r_md_busy) begin
            r_md_cnt  <= is_div ? c_div_load : c_mult_load;
            r_md_busy <= 1'b1;
        end else if (r_md_cnt != '0) begin
            r_md_cnt  <= r_md_cnt - c_one;
            r_md_busy <= (r_md_cnt != c_one);
        end
    end

    assign busy = r_md_busy;

`ifndef SYNTHESIS
    property p_start_while_busy_ignored;
        @(posedge clk) disable iff (reset)
            (start && r_md_busy) |=> (r_md_cnt == $past(r_md_cnt) - c_one);
    endproperty
    a_start_while_busy_ignored: assert property (p_start_while_busy_ignored);
`endif

endmodule : md_busy_timer
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stall_ctrl
// Description : Hazard/stall controller: F_D stall, D_E bubble, stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [1:0]       tuse_rs_D,
    input  logic [1:0]       tuse_rt_D,
    input  logic [4:0]       a3_E,
    input  logic [1:0]       tnew_E,
    input  logic [4:0]       a3_M,
    input  logic [1:0]       tnew_M,
    input  logic             md_start_E,
    input  logic             md_is_div_E,
    input  logic             md_use_D,
    output logic             stall,
    output logic             flush_E,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             w_reg_hazard;
    logic             w_md_hazard;
    logic             w_stall;
    logic             w_md_busy;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_reg_hazard = reg_hazard(rs_D, tuse_rs_D, a3_E, tnew_E) |
                          reg_hazard(rs_D, tuse_rs_D, a3_M, tnew_M) |
                          reg_hazard(rt_D, tuse_rt_D, a3_E, tnew_E) |
                          reg_hazard(rt_D, tuse_rt_D, a3_M, tnew_M);

    // The start cycle counts as busy for dependents, before the timer loads.
    assign w_md_hazard = md_use_D && (w_md_busy || md_start_E);
    assign w_stall     = w_reg_hazard || w_md_hazard;

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_E),
        .is_div (md_is_div_E),
        .busy   (w_md_busy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
        end
    end

    assign stall     = w_stall;
    assign flush_E   = w_stall;
    assign md_busy   = w_md_busy;
    assign stall_cnt = r_stall_cnt;

endmodule : stall_ctrl
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stall_ctrl
// Description : Directed self-checking bench for stall_ctrl (CNT_W = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stall_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       rs_D, rt_D, a3_E, a3_M;
    logic [1:0]       tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic             md_start_E, md_is_div_E, md_use_D;
    logic             stall, flush_E, md_busy;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    stall_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .rs_D        (rs_D),
        .rt_D        (rt_D),
        .tuse_rs_D   (tuse_rs_D),
        .tuse_rt_D   (tuse_rt_D),
        .a3_E        (a3_E),
        .tnew_E      (tnew_E),
        .a3_M        (a3_M),
        .tnew_M      (tnew_M),
        .md_start_E  (md_start_E),
        .md_is_div_E (md_is_div_E),
        .md_use_D    (md_use_D),
        .stall       (stall),
        .flush_E     (flush_E),
        .md_busy     (md_busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rs_D = '0; rt_D = '0; a3_E = '0; a3_M = '0;
        tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; tnew_E = '0; tnew_M = '0;
        md_start_E = 1'b0; md_is_div_E = 1'b0; md_use_D = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_busy", {31'd0, md_busy}, 32'd0);
        check_eq("rst_cnt", {28'd0, stall_cnt}, 32'd0);
        // Reg hazard is visible even while reset is held.
        rs_D = 5'd8; tuse_rs_D = 2'd0; a3_E = 5'd8; tnew_E = 2'd1;
        #1;
        check_eq("rst_haz_stall", {31'd0, stall}, 32'd1);
        idle_inputs();
        tick();
        reset = 1'b0;

        // Register hazards, all evaluated between clock edges.
        tick();
        rs_D = 5'd8; tuse_rs_D = 2'd0; a3_E = 5'd8; tnew_E = 2'd1;
        #1;
        check_eq("rs_E_stall", {31'd0, stall}, 32'd1);
        check_eq("rs_E_flush", {31'd0, flush_E}, 32'd1);
        rs_D = 5'd0; a3_E = 5'd0;
        #1;
        check_eq("rs_zero", {31'd0, stall}, 32'd0);
        idle_inputs();
        rt_D = 5'd9; tuse_rt_D = 2'd1; a3_M = 5'd9; tnew_M = 2'd1;
        #1;
        check_eq("rt_M_eq", {31'd0, stall}, 32'd0);
        tuse_rt_D = 2'd0;
        #1;
        check_eq("rt_M_lt", {31'd0, stall}, 32'd1);
        tuse_rt_D = 2'd3;
        #1;
        check_eq("rt_M_none", {31'd0, stall}, 32'd0);
        idle_inputs();
        rt_D = 5'd4; tuse_rt_D = 2'd1; a3_E = 5'd4; tnew_E = 2'd2;
        #1;
        check_eq("rt_E_lt", {31'd0, stall}, 32'd1);
        a3_E = 5'd5;
        #1;
        check_eq("rt_E_diff", {31'd0, stall}, 32'd0);
        idle_inputs();
        #1;
        check_eq("cnt_after_reg", {28'd0, stall_cnt}, 32'd0);

        // Multiply: stall on start cycle plus 5 busy cycles -> 6 counted.
        tick();
        md_start_E = 1'b1; md_is_div_E = 1'b0; md_use_D = 1'b1;
        #1;
        check_eq("mult_start_stall", {31'd0, stall}, 32'd1);
        check_eq("mult_start_busy", {31'd0, md_busy}, 32'd0);
        tick();
        md_start_E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("mult_busy_%0d", i), {31'd0, md_busy}, 32'd1);
            check_eq($sformatf("mult_stall_%0d", i), {31'd0, stall}, 32'd1);
            tick();
        end
        #1;
        check_eq("mult_done_busy", {31'd0, md_busy}, 32'd0);
        check_eq("mult_done_stall", {31'd0, stall}, 32'd0);
        check_eq("mult_cnt", {28'd0, stall_cnt}, 32'd6);
        md_use_D = 1'b0;

        // Divide: 10 busy cycles, re-start on cycle 4 must be ignored.
        tick();
        md_start_E = 1'b1; md_is_div_E = 1'b1;
        tick();
        md_start_E = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            check_eq($sformatf("div_busy_%0d", i), {31'd0, md_busy}, 32'd1);
            if (i == 4) begin
                md_start_E = 1'b1; md_is_div_E = 1'b1;
            end
            tick();
            md_start_E = 1'b0;
        end
        #1;
        check_eq("div_done_busy", {31'd0, md_busy}, 32'd0);
        check_eq("div_cnt_unchanged", {28'd0, stall_cnt}, 32'd6);

        // Asynchronous reset in cycle 3 of a divide.
        tick();
        md_start_E = 1'b1; md_is_div_E = 1'b1; md_use_D = 1'b1;
        tick();
        md_start_E = 1'b0;
        tick();
        tick();
        check_eq("div3_busy", {31'd0, md_busy}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("async_rst_busy", {31'd0, md_busy}, 32'd0);
        check_eq("async_rst_cnt", {28'd0, stall_cnt}, 32'd0);
        reset = 1'b0;
        md_use_D = 1'b0;

        // Fresh multiply after reset gets a full 5-cycle count.
        tick();
        md_start_E = 1'b1; md_is_div_E = 1'b0;
        tick();
        md_start_E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("post_rst_busy_%0d", i), {31'd0, md_busy}, 32'd1);
            tick();
        end
        #1;
        check_eq("post_rst_done", {31'd0, md_busy}, 32'd0);

        // Hold a reg hazard for 20 edges: counter saturates at 4'hF.
        rs_D = 5'd3; tuse_rs_D = 2'd0; a3_M = 5'd3; tnew_M = 2'd2;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check_eq($sformatf("sat_cnt_%0d", i), {28'd0, stall_cnt},
                     (i > 15) ? 32'd15 : 32'(i));
        end
        idle_inputs();
        tick();
        check_eq("sat_hold", {28'd0, stall_cnt}, 32'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_stall_ctrl
`default_nettype wire
